// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: N-digit 7-segment scan controller with a serial
// shift-add-3 binary-to-BCD converter, dp, blanking, blink, overflow.
//
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   bin_data, load  value to convert, one-cycle strobe (ignored while busy)
//   dp_mask         per-digit decimal point enables (live)
//   blink_mask      per-digit blink enables (live)
//   blank_en        leading-zero blanking enable (live)
//   busy, done      conversion running / one-cycle "digits latched" pulse
//   ovf             latched value >= 10**NUM_DIGITS
//   fnd_data        active-low segments, bit7=dp, bits6:0=g..a
//   fnd_com         active-low digit commons, one-hot-zero
module fnd_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 14,
   parameter int SCAN_DIV   = 100_000,
   parameter int BLINK_DIV  = 125
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      bin_data,
   input  logic                  load,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   input  logic                  blank_en,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [7:0]            fnd_data,
   output logic [NUM_DIGITS-1:0] fnd_com
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [63:0] LIMIT = 64'(10 ** NUM_DIGITS);

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t             state, state_nx;
   logic [BIN_W-1:0]   bin_sh;
   logic [BCD_W-1:0]   bcd, bcd_adj, disp;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_pend;
   logic [DIV_W-1:0]   div;
   logic [IDX_W-1:0]   idx;
   logic [BLK_W-1:0]   frame;
   logic               phase_on;
   logic               div_wrap, idx_wrap;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (load) state_nx = S_CONV;
         S_CONV:  if (cnt == CNT_W'(BIN_W - 1)) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state == S_CONV);

   // add-3 correction on every nibble before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (bcd[d*4 +: 4] >= 4'd5)
            bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
   end

   // display only changes in DONE, so partial results never show
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_sh   <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         disp     <= '0;
         ovf      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (load) begin
               bin_sh   <= bin_data;
               bcd      <= '0;
               cnt      <= '0;
               ovf_pend <= (64'(bin_data) >= LIMIT);
            end
            S_CONV: begin
               bcd    <= {bcd_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
               bin_sh <= {bin_sh[BIN_W-2:0], 1'b0};
               cnt    <= cnt + CNT_W'(1);
            end
            S_DONE: begin
               disp <= bcd;
               ovf  <= ovf_pend;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign div_wrap = (div == DIV_W'(SCAN_DIV - 1));
   assign idx_wrap = (idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div      <= '0;
         idx      <= '0;
         frame    <= '0;
         phase_on <= 1'b1;
      end else if (div_wrap) begin
         div <= '0;
         idx <= idx_wrap ? '0 : idx + IDX_W'(1);
         if (idx_wrap) begin
            if (frame == BLK_W'(BLINK_DIV - 1)) begin
               frame    <= '0;
               phase_on <= ~phase_on;
            end else begin
               frame <= frame + BLK_W'(1);
            end
         end
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   always_comb begin
      logic [3:0] nib;
      logic       lz, dp_sel, blk_sel;
      nib     = '0;
      lz      = 1'b1;
      dp_sel  = 1'b0;
      blk_sel = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         fnd_com[i] = (idx != IDX_W'(i));
         if (idx == IDX_W'(i)) begin
            nib     = disp[i*4 +: 4];
            dp_sel  = dp_mask[i];
            blk_sel = blink_mask[i];
         end
         // zero from this digit upward means it is a leading zero
         if (IDX_W'(i) >= idx && disp[i*4 +: 4] != 4'd0)
            lz = 1'b0;
      end
      fnd_data = seg7(nib);
      if (ovf)
         fnd_data = 8'hBF;
      else if (blank_en && lz && idx != '0)
         fnd_data = 8'hFF;
      if (dp_sel)
         fnd_data[7] = 1'b0;
      if (!phase_on && blk_sel)
         fnd_data = 8'hFF;
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed stimulus with a done-driven scoreboard
// monitor checking latched digits, plus scan/blink/reset checks.
module tb_fnd_scan_ctrl;

   localparam int ND = 4;
   localparam int BW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] bin_data = '0;
   logic          load = 1'b0;
   logic [ND-1:0] dp_mask = '0;
   logic [ND-1:0] blink_mask = '0;
   logic          blank_en = 1'b0;
   logic          busy, done, ovf;
   logic [7:0]    fnd_data;
   logic [ND-1:0] fnd_com;

   typedef logic [ND-1:0][7:0] frame_t;
   typedef struct packed {
      logic   ovf;
      frame_t seg;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_busy = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   fnd_scan_ctrl #(
      .NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(4), .BLINK_DIV(2)
   ) dut (
      .clk(clk), .rst(rst), .bin_data(bin_data), .load(load),
      .dp_mask(dp_mask), .blink_mask(blink_mask), .blank_en(blank_en),
      .busy(busy), .done(done), .ovf(ovf),
      .fnd_data(fnd_data), .fnd_com(fnd_com)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic grab(output frame_t s);
      s = '1;
      repeat (ND * 4) begin
         @(negedge clk);
         for (int i = 0; i < ND; i++)
            if (!fnd_com[i]) s[i] = fnd_data;
      end
   endtask

   task automatic chk_frame(input string nm, input frame_t s,
                            input frame_t e);
      for (int i = 0; i < ND; i++)
         chk($sformatf("%s_d%0d", nm, i), 32'(s[i]), 32'(e[i]));
   endtask

   task automatic wait_sb();
      int k = 0;
      while ((exp_q.size() != 0 || mon_busy) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("sb_drain", 32'(exp_q.size() == 0 && !mon_busy), 1);
   endtask

   task automatic push_exp(input logic o, input frame_t sg);
      exp_t e;
      e.ovf = o;
      e.seg = sg;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [BW-1:0] v, input logic o,
                        input frame_t sg);
      @(negedge clk);
      push_exp(o, sg);
      bin_data = v;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_sb();
   endtask

   // monitor: each done pulse pops one expectation and checks a frame
   initial begin
      exp_t   e;
      frame_t s;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            mon_busy = 1'b1;
            chk("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("ovf", 32'(ovf), 32'(e.ovf));
               grab(s);
               chk_frame("conv", s, e.seg);
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      frame_t     s;
      logic [3:0] ec;
      int         bc, dk, dn, ix;

      // reset state and scan stepping
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_com", 32'(fnd_com), 32'h0E);
      chk("rst_data", 32'(fnd_data), 32'hC0);
      rst = 1'b0;
      for (int p = 0; p <= 20; p++) begin
         ec = ~(4'b0001 << ((p / 4) % 4));
         chk($sformatf("scan_com_p%0d", p), 32'(fnd_com), 32'(ec));
         chk($sformatf("scan_data_p%0d", p), 32'(fnd_data), 32'hC0);
         @(negedge clk);
      end

      // 1234 with busy/done timing and an ignored second load
      @(negedge clk);
      push_exp(1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
      bin_data = 14'd1234;
      load = 1'b1;
      bc = 0;
      dk = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) load = 1'b0;
         if (k == 4) begin
            bin_data = 14'd55;
            load = 1'b1;
         end
         if (k == 5) load = 1'b0;
         if (busy) bc++;
         if (done && dk < 0) dk = k;
      end
      chk("busy_cycles", 32'(bc), 14);
      chk("done_cycle", 32'(dk), 15);
      wait_sb();

      // blanking, mid zeros and decimal point
      blank_en = 1'b1;
      issue(14'd7, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hF8});
      blank_en = 1'b0;
      grab(s);
      chk_frame("noblank", s, {8'hC0, 8'hC0, 8'hC0, 8'hF8});
      blank_en = 1'b1;
      dp_mask = 4'b0010;
      grab(s);
      chk_frame("dp_blank", s, {8'hFF, 8'hFF, 8'h7F, 8'hF8});
      blank_en = 1'b0;
      grab(s);
      chk_frame("dp_show", s, {8'hC0, 8'hC0, 8'h40, 8'hF8});
      dp_mask = 4'b0000;
      blank_en = 1'b1;
      issue(14'd1005, 1'b0, {8'hF9, 8'hC0, 8'hC0, 8'h92});
      blank_en = 1'b0;

      // overflow boundary, dashes with dp, then recovery
      issue(14'd12000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
      blank_en = 1'b1;
      dp_mask = 4'b0001;
      grab(s);
      chk_frame("ovf_dp", s, {8'hBF, 8'hBF, 8'hBF, 8'h3F});
      dp_mask = 4'b0000;
      blank_en = 1'b0;
      issue(14'd42, 1'b0, {8'hC0, 8'hC0, 8'h99, 8'hA4});
      issue(14'd10000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF});
      issue(14'd42, 1'b0, {8'hC0, 8'hC0, 8'h99, 8'hA4});

      // blink on digit 0, phase aligned by a reset pulse
      @(negedge clk);
      rst = 1'b1;
      blink_mask = 4'b0001;
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 80; p++) begin
         if (p % 4 == 0) begin
            ix = (p / 4) % 4;
            ec = ~(4'b0001 << ix);
            chk($sformatf("blink_com_p%0d", p), 32'(fnd_com), 32'(ec));
            chk($sformatf("blink_data_p%0d", p), 32'(fnd_data),
                (ix == 0 && ((p / 32) % 2) == 1) ? 32'hFF : 32'hC0);
         end
         @(negedge clk);
      end
      blink_mask = 4'b0000;

      // reset in the middle of a conversion
      @(negedge clk);
      bin_data = 14'd9999;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_ovf", 32'(ovf), 0);
      chk("midrst_com", 32'(fnd_com), 32'h0E);
      chk("midrst_data", 32'(fnd_data), 32'hC0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("midrst_no_done", 32'(dn), 0);
      chk("midrst_idle", 32'(busy), 0);
      issue(14'd9999, 1'b0, {8'h90, 8'h90, 8'h90, 8'h90});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
